// File: rtl/wb_reg_bank_pkg.sv
// wb_reg_bank_pkg
// Shared definitions for the Wishbone register bank:
//   - fixed address map anchors (STATUS, first read-only word) and helpers
//     that derive the read/write base and the last valid address from the
//     bank geometry
//   - STATUS register bit positions
//   - width of the wait-state counter
//   - sequencer state type
package wb_reg_bank_pkg;

  localparam int ADR_STATUS      = 0;
  localparam int ADR_RO_BASE     = 1;

  localparam int STATUS_NEW_BIT  = 0;
  localparam int STATUS_SNAP_BIT = 1;

  // Wait states are limited to 0..15.
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // First read/write word sits directly above the read-only block.
  function automatic int rwBase(input int numRo);
    return ADR_RO_BASE + numRo;
  endfunction

  // Highest address that decodes to a real register.
  function automatic int lastAdr(input int numRo, input int numRw);
    return ADR_RO_BASE + numRo + numRw - 1;
  endfunction

endpackage

// File: rtl/wb_reg_bank_fsm.sv
// wb_reg_bank_fsm
// IDLE/WAIT/RESP sequencer of the Wishbone register bank, including the
// wait-state counter.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   i_cyc, i_stb   Wishbone cycle and strobe from the master
//   o_accept       strobe accepted this cycle (IDLE with cyc&stb)
//   o_enterResp    the next cycle is the response cycle; register side
//                  effects of the access are committed on this edge
//   o_resp         current cycle is the response cycle
module wb_reg_bank_fsm
  import wb_reg_bank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_cyc,
  input  logic i_stb,
  output logic o_accept,
  output logic o_enterResp,
  output logic o_resp
);

  // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES cycles before RESP.
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                r_state;
  state_t                w_stateNext;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cntNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Dropping cyc while waiting abandons the access; no response follows.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    o_accept    = 1'b0;
    o_enterResp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cyc && i_stb) begin
          o_accept = 1'b1;
          if (WAIT_STATES == 0) begin
            w_stateNext = ST_RESP;
            o_enterResp = 1'b1;
          end else begin
            w_stateNext = ST_WAIT;
            w_cntNext   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!i_cyc) begin
          w_stateNext = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_stateNext = ST_RESP;
          o_enterResp = 1'b1;
        end else begin
          w_cntNext = r_cnt - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign o_resp = (r_state == ST_RESP);

endmodule

// File: rtl/wb_reg_bank.sv
// wb_reg_bank
// Wishbone classic slave register bank: a STATUS word, NUM_RO read-only
// words read through a coherent snapshot, and NUM_RW read/write words
// staged in a shadow and committed atomically by a write to the last one.
// Build option: WB_REG_BANK_ERR_EN - when defined, out-of-range accesses
// answer with wb_err_o instead of wb_ack_o; otherwise they are acked with
// read data 0 and wb_err_o is held at 0.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i   Wishbone cycle / strobe / write enable
//   wb_adr_i, wb_dat_i            word address, write data
//   wb_dat_o, wb_ack_o, wb_err_o  read data, acknowledge, error
//   ro_data_i, ro_valid_i         live read-only source and its valid pulse
//   rw_data_o, rw_update_o        committed read/write words, commit pulse
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_RO      = 8,
  parameter int NUM_RW      = 6,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADDR_W-1:0]        wb_adr_i,
  input  logic [DATA_W-1:0]        wb_dat_i,
  output logic [DATA_W-1:0]        wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  input  logic [NUM_RO*DATA_W-1:0] ro_data_i,
  input  logic                     ro_valid_i,
  output logic [NUM_RW*DATA_W-1:0] rw_data_o,
  output logic                     rw_update_o
);

  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(ADR_STATUS);
  localparam logic [ADDR_W-1:0] A_RO_FIRST = ADDR_W'(ADR_RO_BASE);
  localparam logic [ADDR_W-1:0] A_RW_FIRST = ADDR_W'(rwBase(NUM_RO));
  localparam logic [ADDR_W-1:0] A_LAST     = ADDR_W'(lastAdr(NUM_RO, NUM_RW));

  logic                     w_accept;
  logic                     w_enterResp;
  logic                     w_resp;

  logic [ADDR_W-1:0]        r_adr;
  logic                     r_we;
  logic [DATA_W-1:0]        r_dat;
  logic [NUM_RO*DATA_W-1:0] r_snapshot;
  logic                     r_new;
  logic                     r_snap;
  logic [NUM_RW*DATA_W-1:0] r_shadow;
  logic [NUM_RW*DATA_W-1:0] r_committed;
  logic                     r_update;

  logic [ADDR_W-1:0]        w_adr;
  logic                     w_we;
  logic [DATA_W-1:0]        w_dat;
  logic                     w_takeSnap;
  logic                     w_statusClr;
  logic                     w_rwWrite;
  logic                     w_commit;
  logic [NUM_RW*DATA_W-1:0] w_shadowNext;
  logic [DATA_W-1:0]        w_rdData;

  wb_reg_bank_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .i_cyc      (wb_cyc_i),
    .i_stb      (wb_stb_i),
    .o_accept   (w_accept),
    .o_enterResp(w_enterResp),
    .o_resp     (w_resp)
  );

  // With no wait states the access commits on the strobe edge itself,
  // before the latched copy exists, so the live bus values are used then.
  assign w_adr = w_accept ? wb_adr_i : r_adr;
  assign w_we  = w_accept ? wb_we_i  : r_we;
  assign w_dat = w_accept ? wb_dat_i : r_dat;

  // Snapshot is taken in the strobe cycle of a word-1 read so that the
  // following reads of the upper words see the same capture.
  assign w_takeSnap  = w_accept && !wb_we_i && (wb_adr_i == A_RO_FIRST);
  assign w_statusClr = w_enterResp && w_we && (w_adr == A_STATUS) &&
                       w_dat[STATUS_NEW_BIT];
  assign w_rwWrite   = w_enterResp && w_we &&
                       (w_adr >= A_RW_FIRST) && (w_adr <= A_LAST);
  assign w_commit    = w_rwWrite && (w_adr == A_LAST);

  always_comb begin
    w_shadowNext = r_shadow;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_adr == A_RW_FIRST + ADDR_W'(i)) begin
        w_shadowNext[i*DATA_W +: DATA_W] = w_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_adr <= '0;
      r_we  <= 1'b0;
      r_dat <= '0;
    end else if (w_accept) begin
      r_adr <= wb_adr_i;
      r_we  <= wb_we_i;
      r_dat <= wb_dat_i;
    end
  end

  // A word-1 read in the same cycle as ro_valid_i wins: NEW ends cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snapshot <= '0;
      r_snap     <= 1'b0;
      r_new      <= 1'b0;
    end else if (w_takeSnap) begin
      r_snapshot <= ro_data_i;
      r_snap     <= 1'b1;
      r_new      <= 1'b0;
    end else if (ro_valid_i) begin
      r_new      <= 1'b1;
    end else if (w_statusClr) begin
      r_new      <= 1'b0;
    end
  end

  // Commit happens on the edge entering RESP, so rw_data_o already holds
  // the new value while rw_update_o and the ack are high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow    <= '0;
      r_committed <= '0;
      r_update    <= 1'b0;
    end else begin
      r_update <= w_commit;
      if (w_rwWrite) begin
        r_shadow <= w_shadowNext;
      end
      if (w_commit) begin
        r_committed <= w_shadowNext;
      end
    end
  end

  // Read mux; unmatched addresses read as zero.
  always_comb begin
    w_rdData = '0;
    if (r_adr == A_STATUS) begin
      w_rdData[STATUS_NEW_BIT]  = r_new;
      w_rdData[STATUS_SNAP_BIT] = r_snap;
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (r_adr == A_RO_FIRST + ADDR_W'(i)) begin
        w_rdData = r_snapshot[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < NUM_RW; i++) begin
      if (r_adr == A_RW_FIRST + ADDR_W'(i)) begin
        w_rdData = r_committed[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wb_dat_o    = (w_resp && !r_we) ? w_rdData : '0;
  assign rw_data_o   = r_committed;
  assign rw_update_o = r_update;

`ifdef WB_REG_BANK_ERR_EN
  logic w_inRange;
  assign w_inRange = (r_adr <= A_LAST);
  assign wb_ack_o  = w_resp && w_inRange;
  assign wb_err_o  = w_resp && !w_inRange;
`else
  assign wb_ack_o  = w_resp;
  assign wb_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_reg_bank.sv
`timescale 1ns/1ps
// tb_wb_reg_bank
// Two instances: dutA with no wait states, checked every cycle against a
// word-array model of the register map, and dutB with three wait states
// for latency, abort and mid-access reset behaviour.
module tb_wb_reg_bank;

  localparam int DW  = 8;
  localparam int NRO = 8;
  localparam int NRW = 6;
  localparam int AW  = 4;

`ifdef WB_REG_BANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              aCyc, aStb, aWe;
  logic [AW-1:0]     aAdr;
  logic [DW-1:0]     aDatI, aDatO;
  logic              aAck, aErr;
  logic [NRO*DW-1:0] roData;
  logic              roValid;
  logic [NRW*DW-1:0] aRw;
  logic              aUpd;

  logic              bCyc, bStb, bWe;
  logic [AW-1:0]     bAdr;
  logic [DW-1:0]     bDatI, bDatO;
  logic              bAck, bErr;
  logic [NRO*DW-1:0] bRoData;
  logic              bRoValid;
  logic [NRW*DW-1:0] bRw;
  logic              bUpd;

  wb_reg_bank #(.DATA_W(DW), .NUM_RO(NRO), .NUM_RW(NRW), .WAIT_STATES(0), .ADDR_W(AW)) dutA (
    .clk(clk), .reset(reset), .wb_cyc_i(aCyc), .wb_stb_i(aStb), .wb_we_i(aWe),
    .wb_adr_i(aAdr), .wb_dat_i(aDatI), .wb_dat_o(aDatO), .wb_ack_o(aAck), .wb_err_o(aErr),
    .ro_data_i(roData), .ro_valid_i(roValid), .rw_data_o(aRw), .rw_update_o(aUpd)
  );

  wb_reg_bank #(.DATA_W(DW), .NUM_RO(NRO), .NUM_RW(NRW), .WAIT_STATES(3), .ADDR_W(AW)) dutB (
    .clk(clk), .reset(reset), .wb_cyc_i(bCyc), .wb_stb_i(bStb), .wb_we_i(bWe),
    .wb_adr_i(bAdr), .wb_dat_i(bDatI), .wb_dat_o(bDatO), .wb_ack_o(bAck), .wb_err_o(bErr),
    .ro_data_i(bRoData), .ro_valid_i(bRoValid), .rw_data_o(bRw), .rw_update_o(bUpd)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Register-map model of dutA.
  logic [DW-1:0] mShadow    [NRW];
  logic [DW-1:0] mCommitted [NRW];
  logic [DW-1:0] mSnap      [NRO];
  bit            mNew, mSnapF;
  logic          expAck, expErr, expUpd;
  logic [DW-1:0] expDat;
  bit            checkEn = 1'b0;
  int            aUpdCount = 0;
  int            bUpdCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NRW*DW-1:0] packCommitted();
    logic [NRW*DW-1:0] v;
    for (int i = 0; i < NRW; i++) v[i*DW +: DW] = mCommitted[i];
    return v;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NRW; i++) begin mShadow[i] = '0; mCommitted[i] = '0; end
    for (int i = 0; i < NRO; i++) mSnap[i] = '0;
    mNew = 1'b0; mSnapF = 1'b0;
    expAck = 1'b0; expErr = 1'b0; expUpd = 1'b0; expDat = '0;
  endtask

  // Per-cycle comparison of dutA against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("a_ack", 64'(aAck), 64'(expAck));
      checkOutput("a_err", 64'(aErr), 64'(expErr));
      checkOutput("a_dat", 64'(aDatO), 64'(expDat));
      checkOutput("a_upd", 64'(aUpd), 64'(expUpd));
      checkOutput("a_rwdata", 64'(aRw), 64'(packCommitted()));
    end
  end

  always @(negedge clk) begin
    if (aUpd) aUpdCount++;
    if (bUpd) bUpdCount++;
  end

  // One dutA access; called just after a rising edge. Optionally pulses
  // ro_valid_i in the strobe cycle with new live data.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                               input bit withValid, input logic [NRO*DW-1:0] validData,
                               output logic [DW-1:0] rdata);
    int a;
    a = int'(adr);
    aCyc = 1'b1; aStb = 1'b1; aWe = we; aAdr = adr; aDatI = dat;
    if (withValid) begin roData = validData; roValid = 1'b1; end
    @(posedge clk); #1;
    if (!we && a == 1) begin
      for (int i = 0; i < NRO; i++) mSnap[i] = roData[i*DW +: DW];
      mSnapF = 1'b1; mNew = 1'b0;
    end else if (withValid) begin
      mNew = 1'b1;
    end
    aCyc = 1'b0; aStb = 1'b0; aWe = 1'b0; roValid = 1'b0;
    expAck = ERR_EN ? (a <= NRO + NRW) : 1'b1;
    expErr = ERR_EN ? (a >  NRO + NRW) : 1'b0;
    expDat = '0; expUpd = 1'b0;
    if (we) begin
      if (a == 0) begin
        if (dat[0]) mNew = 1'b0;
      end else if (a > NRO && a <= NRO + NRW) begin
        mShadow[a - NRO - 1] = dat;
        if (a == NRO + NRW) begin
          for (int i = 0; i < NRW; i++) mCommitted[i] = mShadow[i];
          expUpd = 1'b1;
        end
      end
    end else begin
      if (a == 0)                 expDat = {6'b0, mSnapF, mNew};
      else if (a <= NRO)          expDat = mSnap[a - 1];
      else if (a <= NRO + NRW)    expDat = mCommitted[a - NRO - 1];
    end
    @(negedge clk);
    rdata = aDatO;
    @(posedge clk); #1;
    expAck = 1'b0; expErr = 1'b0; expUpd = 1'b0; expDat = '0;
  endtask

  task automatic pulseValid(input logic [NRO*DW-1:0] d);
    roData = d; roValid = 1'b1;
    @(posedge clk); #1;
    roValid = 1'b0; mNew = 1'b1;
  endtask

  // One dutB access, observed for a fixed 10-cycle window. dropAfter>0
  // drops cyc at the start of that cycle after the strobe cycle.
  task automatic bAccess(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input int dropAfter, output int ackCycle, output int ackCount,
                         output logic [DW-1:0] rdata);
    ackCycle = -1; ackCount = 0; rdata = '0;
    bCyc = 1'b1; bStb = 1'b1; bWe = we; bAdr = adr; bDatI = dat;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ackCount > 0 || c == dropAfter) begin bCyc = 1'b0; bStb = 1'b0; bWe = 1'b0; end
      @(negedge clk);
      if (bAck) begin
        ackCount++;
        if (ackCycle < 0) begin ackCycle = c; rdata = bDatO; end
      end
    end
    bCyc = 1'b0; bStb = 1'b0; bWe = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    int ackCyc, ackCnt;
    logic [NRO*DW-1:0] onesVal;
    onesVal = '1;
    resetModel();
    reset = 1'b0;
    aCyc = 0; aStb = 0; aWe = 0; aAdr = '0; aDatI = '0; roData = '0; roValid = 0;
    bCyc = 0; bStb = 0; bWe = 0; bAdr = '0; bDatI = '0; bRoData = '0; bRoValid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;

    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("status_after_reset", 64'(rd), 64'h00);

    pulseValid(64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("status_new", 64'(rd), 64'h01);
    applyStimulus(1'b0, 4'd1, 8'h00, 1'b0, '0, rd);
    checkOutput("ro_word1", 64'(rd), 64'hEF);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("status_snap", 64'(rd), 64'h02);
    roData = onesVal;
    applyStimulus(1'b0, 4'd8, 8'h00, 1'b0, '0, rd);
    checkOutput("ro_word8_coherent", 64'(rd), 64'h01);
    applyStimulus(1'b0, 4'd2, 8'h00, 1'b0, '0, rd);
    checkOutput("ro_word2_coherent", 64'(rd), 64'hCD);

    pulseValid(onesVal);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("status_both", 64'(rd), 64'h03);
    applyStimulus(1'b1, 4'd0, 8'h01, 1'b0, '0, rd);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("status_new_cleared", 64'(rd), 64'h02);

    applyStimulus(1'b0, 4'd1, 8'h00, 1'b1, 64'hFEDC_BA98_7654_3210, rd);
    checkOutput("ro_word1_same_cycle", 64'(rd), 64'h10);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("status_snapshot_wins", 64'(rd), 64'h02);

    applyStimulus(1'b1, 4'd3, 8'h99, 1'b0, '0, rd);
    applyStimulus(1'b0, 4'd3, 8'h00, 1'b0, '0, rd);
    checkOutput("ro_write_ignored", 64'(rd), 64'h54);

    aUpdCount = 0;
    for (int w = 0; w < NRW - 1; w++)
      applyStimulus(1'b1, AW'(NRO + 1 + w), DW'(8'h11 * (w + 1)), 1'b0, '0, rd);
    checkOutput("rw_before_commit", 64'(aRw), 64'h0);
    checkOutput("upd_before_commit", 64'(aUpdCount), 64'd0);
    applyStimulus(1'b1, 4'd14, 8'h66, 1'b0, '0, rd);
    checkOutput("rw_after_commit", 64'(aRw), 64'h6655_4433_2211);
    checkOutput("upd_count", 64'(aUpdCount), 64'd1);
    applyStimulus(1'b0, 4'd10, 8'h00, 1'b0, '0, rd);
    checkOutput("rw_word10_read", 64'(rd), 64'h22);
    applyStimulus(1'b1, 4'd9, 8'hA5, 1'b0, '0, rd);
    applyStimulus(1'b0, 4'd9, 8'h00, 1'b0, '0, rd);
    checkOutput("rw_read_committed", 64'(rd), 64'h11);

    applyStimulus(1'b0, 4'd15, 8'h00, 1'b0, '0, rd);
    checkOutput("out_of_range_read", 64'(rd), 64'h00);
    applyStimulus(1'b1, 4'd15, 8'h77, 1'b0, '0, rd);

    bAccess(1'b0, 4'd0, 8'h00, 0, ackCyc, ackCnt, rd);
    checkOutput("b_read_latency", 64'(ackCyc), 64'd4);
    checkOutput("b_read_ack_count", 64'(ackCnt), 64'd1);
    checkOutput("b_status_reset", 64'(rd), 64'h00);
    bAccess(1'b1, 4'd14, 8'hBB, 2, ackCyc, ackCnt, rd);
    checkOutput("b_abort_last_ack", 64'(ackCnt), 64'd0);
    bAccess(1'b1, 4'd10, 8'hAA, 2, ackCyc, ackCnt, rd);
    checkOutput("b_abort_word_ack", 64'(ackCnt), 64'd0);
    checkOutput("b_abort_rw", 64'(bRw), 64'h0);
    checkOutput("b_abort_upd", 64'(bUpdCount), 64'd0);
    bAccess(1'b1, 4'd9, 8'h5A, 0, ackCyc, ackCnt, rd);
    checkOutput("b_write_latency", 64'(ackCyc), 64'd4);
    bAccess(1'b1, 4'd14, 8'h77, 0, ackCyc, ackCnt, rd);
    checkOutput("b_commit_rw", 64'(bRw), 64'h7700_0000_005A);
    checkOutput("b_commit_upd", 64'(bUpdCount), 64'd1);

    bCyc = 1'b1; bStb = 1'b1; bWe = 1'b0; bAdr = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkEn = 1'b0;
    reset = 1'b0;
    resetModel();
    #1;
    checkOutput("rst_b_ack", 64'(bAck), 64'd0);
    checkOutput("rst_b_err", 64'(bErr), 64'd0);
    checkOutput("rst_b_dat", 64'(bDatO), 64'h0);
    checkOutput("rst_b_rw", 64'(bRw), 64'h0);
    checkOutput("rst_b_upd", 64'(bUpd), 64'd0);
    checkOutput("rst_a_rw", 64'(aRw), 64'h0);
    bCyc = 1'b0; bStb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;
    bAccess(1'b0, 4'd0, 8'h00, 0, ackCyc, ackCnt, rd);
    checkOutput("b_after_reset_latency", 64'(ackCyc), 64'd4);
    checkOutput("b_after_reset_status", 64'(rd), 64'h00);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, '0, rd);
    checkOutput("a_after_reset_status", 64'(rd), 64'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
